// File: rtl/fighter_pkg.sv
// Shared fighter constants: state codes, sprite and screen geometry.
// The sprite compositor imports the same package, so the constants stay in step.
// clamp_x limits a signed horizontal position to the visible range [0, SCREEN_W-SPRITE_WIDTH].
package fighter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_WALK         = 4'd1,
    ST_WALKBACK     = 4'd2,
    ST_ATT_START    = 4'd3,
    ST_ATT_END      = 4'd4,
    ST_ATT_PULL     = 4'd5,
    ST_DIRATT_START = 4'd6,
    ST_DIRATT_END   = 4'd7,
    ST_DIRATT_PULL  = 4'd8,
    ST_GOTHIT       = 4'd9,
    ST_BLOCK        = 4'd10
  } state_t;

  localparam int SPRITE_WIDTH  = 113;
  localparam int SPRITE_HEIGHT = 157;
  localparam int SCREEN_W      = 640;
  localparam int X_MAX         = SCREEN_W - SPRITE_WIDTH;
  // Magenta key colour (12-bit RGB) that the compositor treats as see-through.
  localparam logic [11:0] TRANSPARENT_COLOR = 12'hF0F;

  function automatic logic [9:0] clamp_x(input logic signed [11:0] v);
    if (v < 0) return '0;
    else if (v > 12'(X_MAX)) return 10'(X_MAX);
    else return v[9:0];
  endfunction

endpackage

// File: rtl/player_fsm_if.sv
// Player controller bus: per-frame inputs (tick, buttons, hit, opponent position)
// and the sprite-facing outputs (position, state code, hitbox flag, event pulses).
// master: the frame/input side that drives the controller.
// slave:  the player_fsm itself.
interface player_fsm_if;
  logic       frame_tick;
  logic       btn_fwd;
  logic       btn_back;
  logic       btn_attack;
  logic       btn_block;
  logic       hit_in;
  logic [9:0] opponent_x;
  logic [9:0] posx;
  logic [9:0] posy;
  logic [3:0] state;
  logic       attack_active;
  logic       hit_taken;
  logic       blocked;

  modport master (
    output frame_tick, btn_fwd, btn_back, btn_attack, btn_block, hit_in, opponent_x,
    input  posx, posy, state, attack_active, hit_taken, blocked
  );

  modport slave (
    input  frame_tick, btn_fwd, btn_back, btn_attack, btn_block, hit_in, opponent_x,
    output posx, posy, state, attack_active, hit_taken, blocked
  );
endinterface

// File: rtl/anim_timer.sv
// Six-bit loadable down-counter used to time fighter animation phases.
// Ports: clk, rst (sync, active high), load/load_val (load wins over tick),
//        tick (decrement enable), done (counter == 0).
module anim_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       tick,
  output logic       done
);
  logic [5:0] cnt;

  assign done = (cnt == 6'd0);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && !done) cnt <= cnt - 6'd1;
  end
endmodule

// File: rtl/player_fsm.sv
// Per-player fighter controller. Once per frame_tick it consumes a pending hit,
// advances the fighter state machine and moves the sprite horizontally.
// Ports: clk, rst (sync, active high), bus (player_fsm_if.slave: frame_tick,
//        buttons, hit_in, opponent_x in; posx, posy, state, attack_active,
//        hit_taken, blocked out).
// Build option: define PLAYER_FSM_DIRATTACK_EN to enable the directional
// attack chain (states 6/7/8); otherwise every attack edge enters state 3.
module player_fsm
  import fighter_pkg::*;
#(
  parameter int FACING     = 0,
  parameter int START_X    = 100,
  parameter int POSY       = 300,
  parameter int WALK_SPEED = 4,
  parameter int BACK_SPEED = 2,
  parameter int N_START    = 4,
  parameter int N_ACTIVE   = 2,
  parameter int N_PULL     = 6,
  parameter int N_HITSTUN  = 12,
  parameter int MIN_GAP    = 60
) (
  input logic         clk,
  input logic         rst,
  player_fsm_if.slave bus
);
  localparam logic signed [11:0] WALK_S = 12'(WALK_SPEED);
  localparam logic signed [11:0] BACK_S = 12'(BACK_SPEED);
  localparam logic signed [11:0] GAP_S  = 12'(MIN_GAP);

  state_t             st;
  logic [9:0]         posx_q;
  logic               hit_pend, prev_atk;
  logic               attack_active_q, hit_taken_q, blocked_q;
  logic               hit_now, hit_take, atk_edge;
  logic               tmr_load, tmr_done;
  logic [5:0]         tmr_val;
  logic signed [11:0] px, opp, lim, fwd_raw, back_raw;
  logic [9:0]         mv_fwd, mv_back;

  // A hit arriving on the tick cycle itself counts for that tick.
  assign hit_now  = bus.hit_in | hit_pend;
  assign hit_take = hit_now && (st != ST_BLOCK) && (st != ST_GOTHIT);
  assign atk_edge = bus.btn_attack & ~prev_atk;

  assign bus.posx          = posx_q;
  assign bus.posy          = 10'(POSY);
  assign bus.state         = st;
  assign bus.attack_active = attack_active_q;
  assign bus.hit_taken     = hit_taken_q;
  assign bus.blocked       = blocked_q;

  // Candidate positions; the opponent limit is applied before the screen clamp.
  always_comb begin
    px       = $signed({2'b00, posx_q});
    opp      = $signed({2'b00, bus.opponent_x});
    lim      = '0;
    fwd_raw  = px;
    back_raw = px;
    if (FACING == 0) begin
      fwd_raw  = px + WALK_S;
      lim      = (opp < GAP_S) ? 12'sd0 : opp - GAP_S;
      if (fwd_raw > lim) fwd_raw = lim;
      back_raw = px - BACK_S;
    end else begin
      fwd_raw  = px - WALK_S;
      lim      = opp + GAP_S;
      if (fwd_raw < lim) fwd_raw = lim;
      back_raw = px + BACK_S;
    end
    mv_fwd  = clamp_x(fwd_raw);
    mv_back = clamp_x(back_raw);
  end

  // Timer loads with N-1 on the tick that enters a phased state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (bus.frame_tick) begin
      if (hit_take) begin
        tmr_load = 1'b1;
        tmr_val  = 6'(N_HITSTUN - 1);
      end else begin
        case (st)
          ST_IDLE, ST_WALK, ST_WALKBACK: if (atk_edge) begin
            tmr_load = 1'b1;
            tmr_val  = 6'(N_START - 1);
          end
          ST_ATT_START: if (tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = 6'(N_ACTIVE - 1);
          end
          ST_ATT_END: if (tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = 6'(N_PULL - 1);
          end
`ifdef PLAYER_FSM_DIRATTACK_EN
          ST_DIRATT_START: if (tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = 6'(N_ACTIVE - 1);
          end
          ST_DIRATT_END: if (tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = 6'(N_PULL - 1);
          end
`endif
          default: ;
        endcase
      end
    end
  end

  anim_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .tick    (bus.frame_tick),
    .done    (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= ST_IDLE;
      posx_q          <= 10'(START_X);
      hit_pend        <= 1'b0;
      prev_atk        <= 1'b0;
      attack_active_q <= 1'b0;
      hit_taken_q     <= 1'b0;
      blocked_q       <= 1'b0;
    end else begin
      hit_taken_q <= 1'b0;
      blocked_q   <= 1'b0;
      if (!bus.frame_tick) begin
        if (bus.hit_in) hit_pend <= 1'b1;
      end else begin
        hit_pend <= 1'b0;
        prev_atk <= bus.btn_attack;
        if (hit_take) begin
          st              <= ST_GOTHIT;
          hit_taken_q     <= 1'b1;
          attack_active_q <= 1'b0;
        end else begin
          case (st)
            ST_IDLE, ST_WALK, ST_WALKBACK: begin
              if (atk_edge) begin
`ifdef PLAYER_FSM_DIRATTACK_EN
                st <= (bus.btn_fwd | bus.btn_back) ? ST_DIRATT_START : ST_ATT_START;
`else
                st <= ST_ATT_START;
`endif
              end else if (bus.btn_block) begin
                st <= ST_BLOCK;
              end else if (bus.btn_fwd) begin
                st     <= ST_WALK;
                posx_q <= mv_fwd;
              end else if (bus.btn_back) begin
                st     <= ST_WALKBACK;
                posx_q <= mv_back;
              end else begin
                st <= ST_IDLE;
              end
            end
            ST_ATT_START: if (tmr_done) begin
              st              <= ST_ATT_END;
              attack_active_q <= 1'b1;
            end
            ST_ATT_END: if (tmr_done) begin
              st              <= ST_ATT_PULL;
              attack_active_q <= 1'b0;
            end
            ST_ATT_PULL: if (tmr_done) st <= ST_IDLE;
`ifdef PLAYER_FSM_DIRATTACK_EN
            ST_DIRATT_START: if (tmr_done) begin
              st              <= ST_DIRATT_END;
              attack_active_q <= 1'b1;
            end
            ST_DIRATT_END: if (tmr_done) begin
              st              <= ST_DIRATT_PULL;
              attack_active_q <= 1'b0;
            end
            ST_DIRATT_PULL: if (tmr_done) st <= ST_IDLE;
`endif
            // A hit during hitstun is dropped; the stun keeps counting.
            ST_GOTHIT: if (tmr_done) st <= ST_IDLE;
            ST_BLOCK: begin
              if (hit_now) blocked_q <= 1'b1;
              else if (!bus.btn_block) st <= ST_IDLE;
            end
            default: begin
              st              <= ST_IDLE;
              attack_active_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_player_fsm.sv
// Directed bench for player_fsm: a table of per-tick vectors for the main
// instance plus hand-written sequences for pulses, pending hits, reset and clamps.
module tb_player_fsm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  player_fsm_if ifa ();
  player_fsm_if ifb ();
  player_fsm_if ifc ();

  player_fsm #(.FACING(0), .START_X(100)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  player_fsm #(.FACING(0), .START_X(3))   dut_b (.clk(clk), .rst(rst), .bus(ifb));
  player_fsm #(.FACING(1), .START_X(366)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic fwd, back, atk, blk, hit;
    int   opp, st, px;
    logic aa, ht, bl;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic f, b, a, k, h, input int opp, st, px,
                     input logic aa, ht, bl);
    vec_t v;
    v.fwd = f; v.back = b; v.atk = a; v.blk = k; v.hit = h;
    v.opp = opp; v.st = st; v.px = px; v.aa = aa; v.ht = ht; v.bl = bl;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic f, b, a, k);
    ifa.btn_fwd = f; ifa.btn_back = b; ifa.btn_attack = a; ifa.btn_block = k;
    ifb.btn_fwd = f; ifb.btn_back = b; ifb.btn_attack = a; ifb.btn_block = k;
    ifc.btn_fwd = f; ifc.btn_back = b; ifc.btn_attack = a; ifc.btn_block = k;
  endtask

  // One frame tick; afterwards we sit on the negedge following the tick edge.
  task automatic do_tick(input logic hit);
    @(negedge clk);
    ifa.frame_tick = 1'b1; ifb.frame_tick = 1'b1; ifc.frame_tick = 1'b1;
    ifa.hit_in = hit;
    @(negedge clk);
    ifa.frame_tick = 1'b0; ifb.frame_tick = 1'b0; ifc.frame_tick = 1'b0;
    ifa.hit_in = 1'b0;
  endtask

  task automatic pulse_hit();
    @(negedge clk); ifa.hit_in = 1'b1;
    @(negedge clk); ifa.hit_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int s_att, s_end, s_pull;
    drive(0, 0, 0, 0);
    ifa.frame_tick = 0; ifb.frame_tick = 0; ifc.frame_tick = 0;
    ifa.hit_in = 0; ifb.hit_in = 0; ifc.hit_in = 0;
    ifa.opponent_x = 10'd500; ifb.opponent_x = 10'd500; ifc.opponent_x = 10'd300;
    do_reset();

    chk("reset state", ifa.state, 0);
    chk("reset posx", ifa.posx, 100);
    chk("reset posy", ifa.posy, 300);
    chk("reset attack_active", ifa.attack_active, 0);
    chk("reset hit_taken", ifa.hit_taken, 0);
    chk("reset blocked", ifa.blocked, 0);

`ifdef PLAYER_FSM_DIRATTACK_EN
    s_att = 6; s_end = 7; s_pull = 8;
`else
    s_att = 3; s_end = 4; s_pull = 5;
`endif

    // walk forward 10 ticks, then release
    for (int i = 1; i <= 10; i++) add(1, 0, 0, 0, 0, 500, 1, 100 + 4 * i, 0, 0, 0);
    add(0, 0, 0, 0, 0, 500, 0, 140, 0, 0, 0);
    // held attack: 3 x4, 4 x2, 5 x6, idle, no retrigger
    for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 0, 500, 3, 140, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 0, 1, 0, 0, 500, 4, 140, 1, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 0, 500, 5, 140, 0, 0, 0);
    add(0, 0, 1, 0, 0, 500, 0, 140, 0, 0, 0);
    add(0, 0, 1, 0, 0, 500, 0, 140, 0, 0, 0);
    add(0, 0, 0, 0, 0, 500, 0, 140, 0, 0, 0);
    // hit during attack start, 12 ticks of stun, a second hit ignored
    add(0, 0, 1, 0, 0, 500, 3, 140, 0, 0, 0);
    add(0, 0, 0, 0, 1, 500, 9, 140, 0, 1, 0);
    for (int i = 0; i < 11; i++) add(0, 0, 0, 0, (i == 2), 500, 9, 140, 0, 0, 0);
    add(0, 0, 0, 0, 0, 500, 0, 140, 0, 0, 0);
    // block absorbs a hit
    add(0, 0, 0, 1, 0, 500, 10, 140, 0, 0, 0);
    add(0, 0, 0, 1, 1, 500, 10, 140, 0, 0, 1);
    add(0, 0, 0, 1, 0, 500, 10, 140, 0, 0, 0);
    add(0, 0, 0, 0, 0, 500, 0, 140, 0, 0, 0);
    // attack with forward held
    for (int i = 0; i < 4; i++) add(1, 0, 1, 0, 0, 500, s_att, 140, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(1, 0, 1, 0, 0, 500, s_end, 140, 1, 0, 0);
    for (int i = 0; i < 6; i++) add(1, 0, 1, 0, 0, 500, s_pull, 140, 0, 0, 0);
    add(1, 0, 1, 0, 0, 500, 0, 140, 0, 0, 0);
    add(0, 0, 0, 0, 0, 500, 0, 140, 0, 0, 0);
    // walk back, opponent cap, both buttons = forward, cap of 0, left clamp
    add(0, 1, 0, 0, 0, 500, 2, 138, 0, 0, 0);
    add(0, 1, 0, 0, 0, 500, 2, 136, 0, 0, 0);
    add(1, 0, 0, 0, 0, 200, 1, 140, 0, 0, 0);
    add(1, 0, 0, 0, 0, 200, 1, 140, 0, 0, 0);
    add(1, 1, 0, 0, 0, 200, 1, 140, 0, 0, 0);
    add(1, 0, 0, 0, 0, 50, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 500, 2, 0, 0, 0, 0);
    // hit while walking takes priority over movement
    add(1, 0, 0, 0, 1, 500, 9, 0, 0, 1, 0);
    for (int i = 0; i < 11; i++) add(0, 0, 0, 0, 0, 500, 9, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 500, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].fwd, vq[i].back, vq[i].atk, vq[i].blk);
      ifa.opponent_x = 10'(vq[i].opp);
      do_tick(vq[i].hit);
      chk($sformatf("v%0d state", i), ifa.state, vq[i].st);
      chk($sformatf("v%0d posx", i), ifa.posx, vq[i].px);
      chk($sformatf("v%0d attack_active", i), ifa.attack_active, vq[i].aa);
      chk($sformatf("v%0d hit_taken", i), ifa.hit_taken, vq[i].ht);
      chk($sformatf("v%0d blocked", i), ifa.blocked, vq[i].bl);
      chk($sformatf("v%0d posy", i), ifa.posy, 300);
    end

    // hit between ticks is held pending while blocking; pulse lasts one cycle
    drive(0, 0, 0, 1);
    do_tick(0);
    chk("blk enter", ifa.state, 10);
    pulse_hit();
    repeat (3) @(negedge clk);
    chk("blk hold state", ifa.state, 10);
    chk("blk hold no pulse", ifa.blocked, 0);
    do_tick(0);
    chk("blk pending pulse", ifa.blocked, 1);
    chk("blk no hit_taken", ifa.hit_taken, 0);
    @(negedge clk);
    chk("blk pulse width", ifa.blocked, 0);

    // pending hit from mid-frame hits an idle fighter
    drive(0, 0, 0, 0);
    do_tick(0);
    chk("idle after block", ifa.state, 0);
    pulse_hit();
    do_tick(0);
    chk("pending hit state", ifa.state, 9);
    chk("pending hit pulse", ifa.hit_taken, 1);
    @(negedge clk);
    chk("hit pulse width", ifa.hit_taken, 0);

    // reset discards a pending hit
    do_reset();
    pulse_hit();
    do_reset();
    do_tick(0);
    chk("reset drops hit state", ifa.state, 0);
    chk("reset drops hit pulse", ifa.hit_taken, 0);

    // reset mid-attack
    drive(1, 0, 0, 0);
    do_tick(0);
    chk("pre-attack posx", ifa.posx, 104);
    drive(0, 0, 1, 0);
    repeat (5) do_tick(0);
    chk("mid attack state", ifa.state, 4);
    chk("mid attack active", ifa.attack_active, 1);
    do_reset();
    chk("rst attack state", ifa.state, 0);
    chk("rst attack posx", ifa.posx, 100);
    chk("rst attack active", ifa.attack_active, 0);

    // left screen clamp (instance b starts at x=3)
    drive(0, 1, 0, 0);
    do_tick(0);
    chk("clampL 1 posx", ifb.posx, 1);
    chk("clampL 1 state", ifb.state, 2);
    do_tick(0);
    chk("clampL 2 posx", ifb.posx, 0);
    do_tick(0);
    chk("clampL 3 posx", ifb.posx, 0);

    // FACING=1: forward decreases x, floored at opponent + gap
    do_reset();
    drive(1, 0, 0, 0);
    do_tick(0);
    chk("red fwd 1", ifc.posx, 362);
    do_tick(0);
    chk("red fwd 2", ifc.posx, 360);
    do_tick(0);
    chk("red fwd floor", ifc.posx, 360);
    chk("red fwd state", ifc.state, 1);
    drive(0, 1, 0, 0);
    do_tick(0);
    chk("red back posx", ifc.posx, 362);
    chk("red back state", ifc.state, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
